// File: rtl/rx_pkg.sv
// Shared types and defaults for the UART receive control path.
//   rx_state_t        : receive FSM states
//   CLKS_PER_BIT_DEF  : default clock cycles per serial bit
//   DATA_BITS_DEF     : default data bits per frame
package rx_pkg;

  localparam int unsigned CLKS_PER_BIT_DEF = 10;
  localparam int unsigned DATA_BITS_DEF    = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    CHECK,
    LOAD
  } rx_state_t;

endpackage

// File: rtl/rx_bit_timer.sv
// Bit-period timer with a bit counter.
//   clk, rst   : clock, asynchronous active-high reset
//   clr_i      : clear the timer
//   en_i       : advance the timer; it wraps to 0 after term_i
//   term_i     : terminal count (half-bit or full-bit, chosen by the FSM)
//   bit_clr_i  : clear the bit counter
//   bit_inc_i  : count a bit on each wrap
//   wrap_o     : high in the cycle the timer sits at its terminal count
//   bit_cnt_o  : number of wraps counted since bit_clr_i
module rx_bit_timer #(
  parameter int unsigned TW = 4,
  parameter int unsigned BW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr_i,
  input  logic          en_i,
  input  logic [TW-1:0] term_i,
  input  logic          bit_clr_i,
  input  logic          bit_inc_i,
  output logic          wrap_o,
  output logic [BW-1:0] bit_cnt_o
);

  logic [TW-1:0] cnt_q;
  logic [BW-1:0] bit_q;

  assign wrap_o    = en_i && (cnt_q == term_i);
  assign bit_cnt_o = bit_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (en_i) begin
      cnt_q <= wrap_o ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bit_q <= '0;
    end else if (bit_clr_i) begin
      bit_q <= '0;
    end else if (bit_inc_i && wrap_o) begin
      bit_q <= bit_q + 1'b1;
    end
  end

endmodule

// File: rtl/rx_frame_ctrl.sv
// UART receive control: start detect, bit-centre strobes for the external
// stop-bit shift register, framing check and host-visible receive buffer.
//   clk, rst       : clock, asynchronous active-high reset
//   serial_in      : raw RX line (idle high, asynchronous)
//   serial_sync    : synchronised line, feeds the shift register
//   shift_strobe   : one-cycle pulse per bit centre, shift register enable
//   packet_data    : data bits from the shift register
//   stop_bit       : stop bit from the shift register
//   data_read      : host consumed the buffer (one-cycle pulse)
//   rx_data        : buffered byte
//   data_ready     : rx_data holds an unread byte
//   framing_error  : last frame had a zero stop bit (sticky until next start)
//   overrun_error  : an unread byte was overwritten
//   busy           : frame in progress
module rx_frame_ctrl
  import rx_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEF,
  parameter int unsigned DATA_BITS    = DATA_BITS_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 serial_in,
  output logic                 serial_sync,
  output logic                 shift_strobe,
  input  logic [DATA_BITS-1:0] packet_data,
  input  logic                 stop_bit,
  input  logic                 data_read,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 data_ready,
  output logic                 framing_error,
  output logic                 overrun_error,
  output logic                 busy
);

  localparam int unsigned TW = $clog2(CLKS_PER_BIT);
  localparam int unsigned BW = $clog2(DATA_BITS + 2);
  localparam logic [TW-1:0] HALF_TERM = TW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TW-1:0] FULL_TERM = TW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_BITS);

  rx_state_t state_q, state_d;

  logic meta_q, sync_q, sync_prev_q, fall_q;

  logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
  logic ready_q, ready_d;
  logic ovr_q, ovr_d;
  logic fe_q, fe_d;

  logic          tmr_clr, tmr_en, bit_clr, bit_inc, wrap;
  logic [TW-1:0] term;
  logic [BW-1:0] bit_cnt;

  // Falling edge of serial_sync is registered, so START follows the edge
  // of serial_sync by two cycles (three after the raw line is first sampled).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q      <= 1'b1;
      sync_q      <= 1'b1;
      sync_prev_q <= 1'b1;
      fall_q      <= 1'b0;
    end else begin
      meta_q      <= serial_in;
      sync_q      <= meta_q;
      sync_prev_q <= sync_q;
      fall_q      <= sync_prev_q & ~sync_q;
    end
  end

  // Timer controls depend on the current state only, keeping wrap free of
  // any path through the next-state logic.
  assign tmr_clr = (state_q == IDLE);
  assign bit_clr = (state_q == IDLE);
  assign tmr_en  = (state_q == START) || (state_q == DATA);
  assign bit_inc = (state_q == DATA);
  assign term    = (state_q == START) ? HALF_TERM : FULL_TERM;

  rx_bit_timer #(
    .TW (TW),
    .BW (BW)
  ) u_timer (
    .clk       (clk),
    .rst       (rst),
    .clr_i     (tmr_clr),
    .en_i      (tmr_en),
    .term_i    (term),
    .bit_clr_i (bit_clr),
    .bit_inc_i (bit_inc),
    .wrap_o    (wrap),
    .bit_cnt_o (bit_cnt)
  );

  always_comb begin
    state_d   = state_q;
    rx_data_d = rx_data_q;
    ready_d   = ready_q;
    ovr_d     = ovr_q;
    fe_d      = fe_q;

    if (data_read) begin
      ready_d = 1'b0;
      ovr_d   = 1'b0;
    end

    unique case (state_q)
      IDLE: begin
        if (fall_q) begin
          state_d = START;
          fe_d    = 1'b0;
        end
      end
      START: begin
        if (wrap) begin
          state_d = sync_q ? IDLE : DATA;
        end
      end
      DATA: begin
        if (wrap && (bit_cnt == LAST_BIT)) begin
          state_d = CHECK;
        end
      end
      CHECK: begin
        if (stop_bit) begin
          state_d = LOAD;
        end else begin
          fe_d    = 1'b1;
          state_d = IDLE;
        end
      end
      LOAD: begin
        rx_data_d = packet_data;
        ready_d   = 1'b1;
        if (ready_q && !data_read) begin
          ovr_d = 1'b1;
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      rx_data_q <= '0;
      ready_q   <= 1'b0;
      ovr_q     <= 1'b0;
      fe_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      rx_data_q <= rx_data_d;
      ready_q   <= ready_d;
      ovr_q     <= ovr_d;
      fe_q      <= fe_d;
    end
  end

  assign serial_sync   = sync_q;
  assign shift_strobe  = (state_q == DATA) && wrap;
  assign rx_data       = rx_data_q;
  assign data_ready    = ready_q;
  assign framing_error = fe_q;
  assign overrun_error = ovr_q;
  assign busy          = (state_q != IDLE);

endmodule

// File: tb/tb_rx_frame_ctrl.sv
// Self-checking bench for rx_frame_ctrl with a behavioural stop-bit shift
// register downstream and a frame-level reference model of the host flags.
module tb_rx_frame_ctrl;

  localparam int unsigned CPB = 10;
  localparam int unsigned DB  = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          serial_in;
  logic          serial_sync;
  logic          shift_strobe;
  logic [DB-1:0] packet_data;
  logic          stop_bit;
  logic          data_read;
  logic [DB-1:0] rx_data;
  logic          data_ready;
  logic          framing_error;
  logic          overrun_error;
  logic          busy;

  logic [DB:0]   sr = '1;
  int unsigned   cyc = 0;
  int unsigned   strobe_q[$];
  int unsigned   busy_rise = 0, busy_fall = 0, fe_fall = 0;
  logic          busy_d = 1'b0, fe_d = 1'b0;

  int            n_cmp = 0;
  int            n_bad = 0;

  logic [DB-1:0] m_data;
  logic          m_ready, m_ovr, m_fe;

  rx_frame_ctrl #(
    .CLKS_PER_BIT (CPB),
    .DATA_BITS    (DB)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .serial_in     (serial_in),
    .serial_sync   (serial_sync),
    .shift_strobe  (shift_strobe),
    .packet_data   (packet_data),
    .stop_bit      (stop_bit),
    .data_read     (data_read),
    .rx_data       (rx_data),
    .data_ready    (data_ready),
    .framing_error (framing_error),
    .overrun_error (overrun_error),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Downstream 9-bit shift register, LSB-first line order.
  always @(posedge clk) if (shift_strobe) sr <= {serial_sync, sr[DB:1]};
  assign packet_data = sr[DB-1:0];
  assign stop_bit    = sr[DB];

  always @(negedge clk) begin
    if (shift_strobe) strobe_q.push_back(cyc);
    if (busy && !busy_d) busy_rise = cyc;
    if (!busy && busy_d) busy_fall = cyc;
    if (!framing_error && fe_d) fe_fall = cyc;
    busy_d = busy;
    fe_d   = framing_error;
  end

  // Reference model: effect of one complete frame on the host-visible flags.
  task automatic model_frame(input logic [DB-1:0] d, input logic stop, input logic rd);
    m_fe = 1'b0;
    if (stop) begin
      m_ovr   = rd ? 1'b0 : (m_ready ? 1'b1 : m_ovr);
      m_ready = 1'b1;
      m_data  = d;
    end else begin
      m_fe = 1'b1;
      if (rd) begin
        m_ready = 1'b0;
        m_ovr   = 1'b0;
      end
    end
  endtask

  task automatic model_read();
    m_ready = 1'b0;
    m_ovr   = 1'b0;
  endtask

  // Drives start, data (LSB first) and stop; returns just after edge t0+99,
  // where t0 is the first edge that samples the low start bit.
  task automatic send_frame(input logic [DB-1:0] d, input logic stop, output int unsigned t0);
    logic [DB+1:0] bits;
    bits = {stop, d, 1'b0};
    @(posedge clk); #1;
    t0 = cyc + 1;
    strobe_q.delete();
    for (int i = 0; i < DB + 2; i++) begin
      serial_in = bits[i];
      repeat (CPB) @(posedge clk);
      #1;
    end
    serial_in = 1'b1;
  endtask

  task automatic pulse_read();
    data_read = 1'b1;
    @(posedge clk); #1;
    data_read = 1'b0;
  endtask

  task automatic idle(input int unsigned n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; serial_in = 1'b1; data_read = 1'b0;
    m_data = '0; m_ready = 1'b0; m_ovr = 1'b0; m_fe = 1'b0;
    idle(3);
    n_cmp++;
    if ({serial_sync, shift_strobe, busy} !== 3'b100) begin
      n_bad++;
      $display("FAIL reset_ctl: got sync/strobe/busy=%b want 100", {serial_sync, shift_strobe, busy});
    end
    n_cmp++;
    if ({data_ready, overrun_error, framing_error, rx_data} !== {3'b000, 8'h00}) begin
      n_bad++;
      $display("FAIL reset_buf: got rdy/ovr/fe=%b data=%h want 000 00",
               {data_ready, overrun_error, framing_error}, rx_data);
    end
    rst = 1'b0;
    idle(4);
  endtask

  task automatic test_basic();
    int unsigned t0;
    logic ok;
    send_frame(8'hA5, 1'b1, t0);
    model_frame(8'hA5, 1'b1, 1'b0);
    n_cmp++;
    if (busy_rise !== t0 + 3) begin
      n_bad++;
      $display("FAIL basic_start: busy rose at %0d want %0d", busy_rise - t0, 3);
    end
    n_cmp++;
    if (strobe_q.size() !== 9) begin
      n_bad++;
      $display("FAIL basic_nstrobe: got %0d want 9", strobe_q.size());
    end
    ok = 1'b1;
    foreach (strobe_q[k]) if (strobe_q[k] != t0 + 17 + 10 * k) ok = 1'b0;
    n_cmp++;
    if (ok !== 1'b1) begin
      n_bad++;
      $display("FAIL basic_strobe_time: first at t0+%0d want t0+17 spaced 10",
               strobe_q.size() > 0 ? strobe_q[0] - t0 : 0);
    end
    n_cmp++;
    if (data_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL basic_ready_early: got %b at t0+99 want 0", data_ready);
    end
    idle(1);
    n_cmp++;
    if ({data_ready, overrun_error, framing_error, rx_data} !== {m_ready, m_ovr, m_fe, m_data}) begin
      n_bad++;
      $display("FAIL basic_load: got %b/%h want %b/%h at t0+100",
               {data_ready, overrun_error, framing_error}, rx_data, {m_ready, m_ovr, m_fe}, m_data);
    end
  endtask

  task automatic test_framing();
    int unsigned t0;
    pulse_read();
    model_read();
    n_cmp++;
    if ({data_ready, overrun_error} !== 2'b00) begin
      n_bad++;
      $display("FAIL read_clear: got rdy/ovr=%b want 00", {data_ready, overrun_error});
    end
    idle(3);
    send_frame(8'h3C, 1'b0, t0);
    model_frame(8'h3C, 1'b0, 1'b0);
    n_cmp++;
    if ({data_ready, framing_error, rx_data} !== {m_ready, m_fe, m_data}) begin
      n_bad++;
      $display("FAIL frame_err: got rdy/fe=%b data=%h want %b %h",
               {data_ready, framing_error}, rx_data, {m_ready, m_fe}, m_data);
    end
    idle(3);
    send_frame(8'h55, 1'b1, t0);
    model_frame(8'h55, 1'b1, 1'b0);
    n_cmp++;
    if (fe_fall !== t0 + 3) begin
      n_bad++;
      $display("FAIL fe_clear_time: cleared at t0+%0d want t0+3", fe_fall - t0);
    end
    idle(1);
    n_cmp++;
    if ({data_ready, overrun_error, framing_error, rx_data} !== {m_ready, m_ovr, m_fe, m_data}) begin
      n_bad++;
      $display("FAIL frame_recover: got %b/%h want %b/%h",
               {data_ready, overrun_error, framing_error}, rx_data, {m_ready, m_ovr, m_fe}, m_data);
    end
  endtask

  task automatic test_overrun();
    int unsigned t0;
    pulse_read();
    model_read();
    idle(2);
    send_frame(8'h11, 1'b1, t0);
    model_frame(8'h11, 1'b1, 1'b0);
    idle(2);
    send_frame(8'h22, 1'b1, t0);
    model_frame(8'h22, 1'b1, 1'b0);
    idle(1);
    n_cmp++;
    if ({data_ready, overrun_error, rx_data} !== {m_ready, m_ovr, m_data}) begin
      n_bad++;
      $display("FAIL overrun_set: got rdy/ovr=%b data=%h want %b %h",
               {data_ready, overrun_error}, rx_data, {m_ready, m_ovr}, m_data);
    end
    pulse_read();
    model_read();
    n_cmp++;
    if ({data_ready, overrun_error} !== {m_ready, m_ovr}) begin
      n_bad++;
      $display("FAIL overrun_read: got rdy/ovr=%b want %b", {data_ready, overrun_error}, {m_ready, m_ovr});
    end
  endtask

  task automatic test_glitch();
    int unsigned t0;
    idle(2);
    strobe_q.delete();
    t0 = cyc + 1;
    serial_in = 1'b0;
    idle(3);
    serial_in = 1'b1;
    idle(15);
    n_cmp++;
    if ({busy_rise - t0, busy_fall - t0} !== {32'd3, 32'd8}) begin
      n_bad++;
      $display("FAIL glitch_busy: busy t0+%0d..t0+%0d want t0+3..t0+8", busy_rise - t0, busy_fall - t0);
    end
    n_cmp++;
    if ({strobe_q.size() == 0, busy, data_ready, overrun_error, framing_error, rx_data} !==
        {1'b1, 1'b0, m_ready, m_ovr, m_fe, m_data}) begin
      n_bad++;
      $display("FAIL glitch_quiet: strobes=%0d busy=%b flags=%b data=%h want 0 0 %b %h",
               strobe_q.size(), busy, {data_ready, overrun_error, framing_error}, rx_data,
               {m_ready, m_ovr, m_fe}, m_data);
    end
  endtask

  task automatic test_read_in_load();
    int unsigned t0;
    send_frame(8'h77, 1'b1, t0);
    model_frame(8'h77, 1'b1, 1'b0);
    idle(2);
    send_frame(8'h88, 1'b1, t0);
    pulse_read();
    model_frame(8'h88, 1'b1, 1'b1);
    n_cmp++;
    if ({data_ready, overrun_error, rx_data} !== {m_ready, m_ovr, m_data}) begin
      n_bad++;
      $display("FAIL read_in_load: got rdy/ovr=%b data=%h want %b %h",
               {data_ready, overrun_error}, rx_data, {m_ready, m_ovr}, m_data);
    end
  endtask

  task automatic test_reset_mid();
    int unsigned t0;
    logic [DB+1:0] bits;
    bits = {1'b1, 8'h99, 1'b0};
    @(posedge clk); #1;
    t0 = cyc + 1;
    strobe_q.delete();
    for (int i = 0; i < 5; i++) begin
      serial_in = bits[i];
      idle(CPB);
    end
    n_cmp++;
    if ({strobe_q.size() == 4, busy, data_ready} !== 3'b111) begin
      n_bad++;
      $display("FAIL mid_pre: strobes=%0d busy=%b rdy=%b want 4 1 1", strobe_q.size(), busy, data_ready);
    end
    serial_in = 1'b1;
    rst = 1'b1;
    #1;
    n_cmp++;
    if ({serial_sync, shift_strobe, busy, data_ready, overrun_error, framing_error, rx_data} !==
        {1'b1, 5'b00000, 8'h00}) begin
      n_bad++;
      $display("FAIL mid_reset: got sync/strb/busy/rdy/ovr/fe=%b data=%h want 100000 00",
               {serial_sync, shift_strobe, busy, data_ready, overrun_error, framing_error}, rx_data);
    end
    m_data = '0; m_ready = 1'b0; m_ovr = 1'b0; m_fe = 1'b0;
    idle(2);
    rst = 1'b0;
    idle(3);
    send_frame(8'hF0, 1'b1, t0);
    model_frame(8'hF0, 1'b1, 1'b0);
    idle(1);
    n_cmp++;
    if ({data_ready, overrun_error, framing_error, rx_data} !== {m_ready, m_ovr, m_fe, m_data}) begin
      n_bad++;
      $display("FAIL mid_after: got %b/%h want %b/%h",
               {data_ready, overrun_error, framing_error}, rx_data, {m_ready, m_ovr, m_fe}, m_data);
    end
  endtask

  task automatic test_random();
    int unsigned t0;
    logic [DB-1:0] d;
    logic stop, rd;
    for (int n = 0; n < 8; n++) begin
      d    = DB'($urandom);
      stop = ($urandom_range(0, 3) != 0);
      rd   = ($urandom_range(0, 3) == 0);
      send_frame(d, stop, t0);
      if (rd) pulse_read(); else idle(1);
      model_frame(d, stop, rd);
      n_cmp++;
      if ({strobe_q.size() == 9, data_ready, overrun_error, framing_error, rx_data} !==
          {1'b1, m_ready, m_ovr, m_fe, m_data}) begin
        n_bad++;
        $display("FAIL rand_frame%0d: strobes=%0d got %b/%h want %b/%h", n, strobe_q.size(),
                 {data_ready, overrun_error, framing_error}, rx_data, {m_ready, m_ovr, m_fe}, m_data);
      end
      idle($urandom_range(1, 4));
      if ($urandom_range(0, 2) == 0) begin
        pulse_read();
        model_read();
        n_cmp++;
        if ({data_ready, overrun_error} !== {m_ready, m_ovr}) begin
          n_bad++;
          $display("FAIL rand_read%0d: got rdy/ovr=%b want %b", n, {data_ready, overrun_error}, {m_ready, m_ovr});
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_framing();
    test_overrun();
    test_glitch();
    test_read_in_load();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/rx_frame_ctrl.md
Name: rx_frame_ctrl

Overview:
- Receive-side control stage of the UART RX path.
- Detects the start bit and times bit centres. Pulses shift_strobe into the downstream 9-bit stop-bit shift register.
- Consumes that register's packet_data/stop_bit, checks framing and loads a host-visible buffer with data_ready/overrun status.
- Sits between the serial pin and the bus-side read logic; also supplies the synchronised serial bit to the shift register.

Parameters:
- CLKS_PER_BIT, 10, clock cycles per serial bit (even, >= 4).
- DATA_BITS, 8, data bits per frame; frame = start + DATA_BITS + 1 stop.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- serial_in  input  1  raw RX line, idle high, asynchronous to clk.
- serial_sync  output  1  2-flop synchronised serial_in; feeds the shift register serial input.
- shift_strobe  output  1  one-cycle pulse at each bit centre; feeds the shift register enable.
- packet_data  input  DATA_BITS  parallel data from the shift register.
- stop_bit  input  1  stop bit from the shift register.
- data_read  input  1  one-cycle pulse from the host: buffer consumed.
- rx_data  output  DATA_BITS  buffered received byte.
- data_ready  output  1  rx_data holds an unread byte.
- framing_error  output  1  last frame had stop bit = 0.
- overrun_error  output  1  a new byte overwrote an unread byte.
- busy  output  1  a frame is in progress (state != IDLE).

Behaviour:
- Reset values:
  - Synchroniser flops are 1, so the line reads idle.
  - serial_sync is 1.
  - shift_strobe, data_ready, framing_error, overrun_error and busy are 0.
  - rx_data is 0; state is IDLE; counters are 0.
- Reset asserted mid-frame aborts the frame immediately. No load occurs.
- Start detect: falling edge on serial_sync (previous 1, current 0) while in IDLE.
  - State goes to START next cycle and the bit counter clears.
  - framing_error clears on the same edge.
- START: timer counts 0..CLKS_PER_BIT/2-1. At the last count, sample serial_sync.
  - If 0 → DATA, timer cleared.
  - If 1 → IDLE (glitch rejected; no strobe issued, no flags changed).
- DATA: timer counts 0..CLKS_PER_BIT-1 and wraps.
  - On each wrap cycle, shift_strobe=1 for exactly one cycle and the bit counter increments.
  - After the (DATA_BITS+1)th strobe → CHECK.
- CHECK (1 cycle; shift register outputs are now stable):
  - stop_bit=1 → LOAD.
  - stop_bit=0 → framing_error<=1, go to IDLE; rx_data and data_ready are unchanged.
- LOAD (1 cycle):
  - rx_data<=packet_data and data_ready<=1.
  - If data_ready was 1 and data_read is 0 this cycle, overrun_error<=1. Then → IDLE.
- data_read:
  - Clears data_ready and overrun_error next cycle.
  - If it coincides with LOAD, LOAD wins: data_ready stays 1 and overrun is not set.
- framing_error is sticky until the next start detect or reset; data_read does not clear it.
- Falling edges on serial_sync outside IDLE are ignored.
- The next frame may start in the IDLE cycle immediately after LOAD/CHECK (back-to-back frames with a one-bit stop).
- Latency, CLKS_PER_BIT=10: serial_in falls before clock edge t0.
  - START entered at t0+3.
  - First strobe at t0+17; strobes every 10 cycles thereafter.
  - 9th strobe at t0+97; CHECK at t0+98; LOAD at t0+99.
  - data_ready=1 from t0+100.
- Widths:
  - Timer is $clog2(CLKS_PER_BIT) bits.
  - Bit counter is $clog2(DATA_BITS+2) bits.
  - All compares are unsigned.

Decomposition:
- Package rx_pkg holds:
  - enum rx_state_t {IDLE, START, DATA, CHECK, LOAD};
  - localparam defaults for CLKS_PER_BIT and DATA_BITS.
- Sub-module rx_bit_timer:
  - Parameterised counter with clear, enable and a programmable terminal count.
  - Outputs a wrap pulse and the bit count.
  - Instantiated once; the FSM selects the half-bit or full-bit terminal.

Test Plan (CLKS_PER_BIT=10, shift register instantiated downstream):
- Frame 0xA5, stop=1 → 9 shift_strobe pulses 10 cycles apart; data_ready rises at t0+100; rx_data=0xA5; framing_error=0.
- Frame 0x3C with stop=0 → framing_error=1 after CHECK; data_ready stays 0; next valid frame 0x55 clears framing_error at its start and loads 0x55.
- Two frames 0x11 then 0x22, no data_read → rx_data=0x22, data_ready=1, overrun_error=1; a data_read pulse then clears both flags.
- 3-cycle low glitch on idle line → START aborts at the half-bit sample; no shift_strobe, no flag changes, busy returns to 0.
- data_read pulsed exactly in the LOAD cycle of a second frame → data_ready=1, overrun_error=0, rx_data=new byte.
- rst asserted mid-DATA (after 4 strobes) → all outputs 0 immediately; a following full frame 0xF0 receives correctly.
